// File: rtl/axi_vga_fill.sv
// AXI4-Lite write initiator that fills a rectangle of VGA memory with one word, one beat at a time.
// Optional macro AXI_VGA_FILL_ABORT_EN: a non-OKAY write response ends the job early.
module axi_vga_fill #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned COL_WIDTH    = 11,
  parameter int unsigned ROW_WIDTH    = 11,
  parameter int unsigned STRIDE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [STRIDE_WIDTH-1:0] stride,
  input  logic [COL_WIDTH-1:0]    cols,
  input  logic [ROW_WIDTH-1:0]    rows,
  input  logic [31:0]             fill_data,
  input  logic [3:0]              fill_strb,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [31:0]             axi_wdata,
  output logic [3:0]              axi_wstrb,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    aw_ok_q, aw_ok_d;
  logic                    w_ok_q, w_ok_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [COL_WIDTH-1:0]    cols_q, cols_d;
  logic [ROW_WIDTH-1:0]    rows_q, rows_d;
  logic [COL_WIDTH-1:0]    col_q, col_d;
  logic [ROW_WIDTH-1:0]    row_q, row_d;

  logic                    last_col, last_row;
  logic [COL_WIDTH-1:0]    col_inc;
  logic [ADDR_WIDTH-1:0]   next_row_base;
  logic [ADDR_WIDTH-1:0]   start_base;

  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_ok_d    = aw_ok_q;
    w_ok_d     = w_ok_q;
    err_d      = err_q;
    awaddr_d   = awaddr_q;
    row_base_d = row_base_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    stride_d   = stride_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    col_d      = col_q;
    row_d      = row_q;

    last_col      = (col_q == cols_q - COL_WIDTH'(1));
    last_row      = (row_q == rows_q - ROW_WIDTH'(1));
    col_inc       = col_q + COL_WIDTH'(1);
    next_row_base = row_base_q + ADDR_WIDTH'(stride_q);
    start_base    = base_addr & ~ADDR_WIDTH'(3);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d   = stride;
          cols_d     = cols;
          rows_d     = rows;
          wdata_d    = fill_data;
          wstrb_d    = fill_strb;
          err_d      = 1'b0;
          col_d      = '0;
          row_d      = '0;
          row_base_d = start_base;
          awaddr_d   = start_base;
          if (cols == '0 || rows == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ISSUE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_ok_d   = 1'b0;
            w_ok_d    = 1'b0;
          end
        end
      end
      // Handshakes are latched in aw_ok/w_ok so either order works; RESP follows one cycle after both.
      S_ISSUE: begin
        if (awvalid_q && axi_awready) begin
          awvalid_d = 1'b0;
          aw_ok_d   = 1'b1;
        end
        if (wvalid_q && axi_wready) begin
          wvalid_d = 1'b0;
          w_ok_d   = 1'b1;
        end
        if (aw_ok_q && w_ok_q) state_d = S_RESP;
      end
      S_RESP: begin
        if (axi_bvalid) begin
          state_d = S_NEXT;
          if (axi_bresp != 2'b00) begin
            err_d = 1'b1;
`ifdef AXI_VGA_FILL_ABORT_EN
            state_d = S_DONE;
`endif
          end
        end
      end
      S_NEXT: begin
        if (last_col && last_row) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_ISSUE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_ok_d   = 1'b0;
          w_ok_d    = 1'b0;
          if (last_col) begin
            col_d      = '0;
            row_d      = row_q + ROW_WIDTH'(1);
            row_base_d = next_row_base;
            awaddr_d   = next_row_base;
          end else begin
            col_d    = col_inc;
            awaddr_d = row_base_q + ADDR_WIDTH'({col_inc, 2'b00});
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_ok_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      err_q      <= 1'b0;
      awaddr_q   <= '0;
      row_base_q <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      stride_q   <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_ok_q    <= aw_ok_d;
      w_ok_q     <= w_ok_d;
      err_q      <= err_d;
      awaddr_q   <= awaddr_d;
      row_base_q <= row_base_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      stride_q   <= stride_d;
      cols_q     <= cols_d;
      rows_q     <= rows_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = (state_q == S_RESP);

endmodule

// File: tb/tb_axi_vga_fill.sv
// Directed bench for axi_vga_fill: AXI-Lite slave responder, address scoreboard, protocol monitor.
module tb_axi_vga_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] stride;
  logic [10:0] cols;
  logic [10:0] rows;
  logic [31:0] fill_data;
  logic [3:0]  fill_strb;
  logic        busy, done, err;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;

  axi_vga_fill #(
    .ADDR_WIDTH(32), .COL_WIDTH(11), .ROW_WIDTH(11), .STRIDE_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .cols(cols), .rows(rows), .fill_data(fill_data), .fill_strb(fill_strb),
    .busy(busy), .done(done), .err(err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;

`ifdef AXI_VGA_FILL_ABORT_EN
  localparam int T4_WORDS = 2;
`else
  localparam int T4_WORDS = 4;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_strb = '0;

  int aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  int b_count = 0, err_at = -1;
  bit got_aw = 0, got_w = 0;
  bit aw_hs = 0, w_hs = 0, b_hs = 0;
  int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  int aw_hs_cnt = 0, awvalid_hi_cnt = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave responder: programmable ready delays, one B response per AW/W pair.
  initial begin : slave
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        axi_bvalid = 1'b0; axi_bresp = 2'b00;
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
        axi_awready = (aw_delay == 0);
        axi_wready  = (w_delay == 0);
      end else begin
        if (b_hs) begin axi_bvalid = 1'b0; b_count++; end
        if (aw_hs) begin got_aw = 1; aw_cnt = 0; end
        if (w_hs) begin got_w = 1; w_cnt = 0; end
        if (got_aw && got_w && !axi_bvalid) begin
          axi_bvalid = 1'b1;
          axi_bresp  = (b_count == err_at) ? 2'b10 : 2'b00;
          got_aw = 0; got_w = 0;
        end
        if (aw_delay == 0) axi_awready = 1'b1;
        else if (axi_awvalid) begin axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else axi_awready = 1'b0;
        if (w_delay == 0) axi_wready = 1'b1;
        else if (axi_wvalid) begin axi_wready = (w_cnt >= w_delay); w_cnt++; end
        else axi_wready = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on AW handshake, payload checks, valid/payload stability, done width.
  initial begin : monitor
    bit pend_aw, pend_w, prev_done;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [3:0]  prev_wstrb;
    pend_aw = 0; pend_w = 0; prev_done = 0;
    prev_awaddr = '0; prev_wdata = '0; prev_wstrb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pend_aw = 0; pend_w = 0; prev_done = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      end else begin
        if (pend_aw) begin
          check("aw_valid_hold", 64'(axi_awvalid), 64'(1));
          check("aw_addr_stable", 64'(axi_awaddr), 64'(prev_awaddr));
        end
        if (pend_w) begin
          check("w_valid_hold", 64'(axi_wvalid), 64'(1));
          check("w_data_stable", 64'(axi_wdata), 64'(prev_wdata));
          check("w_strb_stable", 64'(axi_wstrb), 64'(prev_wstrb));
        end
        aw_hs = axi_awvalid && axi_awready;
        w_hs  = axi_wvalid && axi_wready;
        b_hs  = axi_bvalid && axi_bready;
        if (axi_awvalid) awvalid_hi_cnt++;
        if (aw_hs) begin
          aw_hs_cnt++;
          aw_hs_cyc = cyc;
          check("aw_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) check("aw_addr", 64'(axi_awaddr), 64'(exp_q.pop_front()));
        end
        if (w_hs) begin
          w_hs_cyc = cyc;
          check("w_data", 64'(axi_wdata), 64'(exp_data));
          check("w_strb", 64'(axi_wstrb), 64'(exp_strb));
        end
        if (axi_bready) check("bready_excl", 64'(axi_awvalid | axi_wvalid), 64'(0));
        if (done) begin
          check("done_width", 64'(prev_done), 64'(0));
          done_cnt++;
        end
        prev_done   = done;
        pend_aw     = axi_awvalid && !axi_awready;
        pend_w      = axi_wvalid && !axi_wready;
        prev_awaddr = axi_awaddr;
        prev_wdata  = axi_wdata;
        prev_wstrb  = axi_wstrb;
      end
    end
  end

  task automatic run_job(input string tag, input logic [31:0] base, input logic [15:0] str,
                         input logic [10:0] c, input logic [10:0] r, input logic [31:0] d,
                         input logic [3:0] s, input int max_words, input bit glitch, output int lat);
    int pushed = 0;
    int d0;
    for (int unsigned ri = 0; ri < 32'(r); ri++)
      for (int unsigned ci = 0; ci < 32'(c); ci++)
        if (pushed < max_words) begin
          exp_q.push_back((base & ~32'h3) + ri * 32'(str) + ci * 32'd4);
          pushed++;
        end
    exp_data = d; exp_strb = s; d0 = done_cnt;
    @(posedge clk); #1;
    base_addr = base; stride = str; cols = c; rows = r; fill_data = d; fill_strb = s; start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 2) check({tag, "_busy"}, 64'(busy), 64'(1));
      if (done) begin lat = i; break; end
      if (i == 1) begin @(posedge clk); #1; start = 1'b0; end
      if (glitch && i == 6) begin
        @(posedge clk); #1;
        base_addr = 32'hDEAD0000; stride = 16'h0800; cols = 11'd7; rows = 11'd7;
        fill_data = ~d; fill_strb = ~s; start = 1'b1;
      end
      if (glitch && i == 7) begin @(posedge clk); #1; start = 1'b0; end
    end
    check({tag, "_done_seen"}, 64'(lat != 0), 64'(1));
    @(negedge clk);
    check({tag, "_idle_after"}, 64'(busy), 64'(0));
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'(1));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, b0, a0, d0;
    bit seen;
    reset = 1'b1; start = 1'b0; base_addr = '0; stride = '0; cols = '0; rows = '0;
    fill_data = '0; fill_strb = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_awvalid", 64'(axi_awvalid), 64'(0));
    check("rst_wvalid", 64'(axi_wvalid), 64'(0));
    check("rst_bready", 64'(axi_bready), 64'(0));
    check("rst_awaddr", 64'(axi_awaddr), 64'(0));
    check("rst_wdata", 64'(axi_wdata), 64'(0));
    check("rst_wstrb", 64'(axi_wstrb), 64'(0));
    @(posedge clk); #2; reset = 1'b0;
    repeat (2) @(negedge clk);

    // T1: 3x2 fill, zero-wait slave
    b0 = b_count;
    run_job("t1", 32'h100, 16'h640, 11'd3, 11'd2, 32'hA5A5A5A5, 4'hF, 1000, 0, lat);
    check("t1_latency", 64'(lat), 64'(26));
    check("t1_bresp_count", 64'(b_count - b0), 64'(6));
    check("t1_err", 64'(err), 64'(0));

    // T2: zero columns completes without traffic
    a0 = awvalid_hi_cnt;
    run_job("t2", 32'h200, 16'h40, 11'd0, 11'd5, 32'h11111111, 4'hF, 1000, 0, lat);
    check("t2_latency", 64'(lat), 64'(2));
    check("t2_no_awvalid", 64'(awvalid_hi_cnt - a0), 64'(0));

    // T3: slow AW channel, W handshakes first
    aw_delay = 3;
    run_job("t3", 32'h2000, 16'h0, 11'd1, 11'd1, 32'h12345678, 4'h3, 1000, 0, lat);
    check("t3_w_before_aw", 64'(aw_hs_cyc - w_hs_cyc), 64'(3));
    aw_delay = 0;

    // T4: SLVERR on the second word
    err_at = b_count + 1;
    a0 = aw_hs_cnt;
    run_job("t4", 32'h3000, 16'h100, 11'd4, 11'd1, 32'hCAFEF00D, 4'hF, T4_WORDS, 0, lat);
    check("t4_err", 64'(err), 64'(1));
    check("t4_writes", 64'(aw_hs_cnt - a0), 64'(T4_WORDS));
    err_at = -1;
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 64'(err), 64'(1));

    // T5: reset while in ISSUE
    aw_delay = 6; w_delay = 6; d0 = done_cnt;
    @(posedge clk); #1;
    base_addr = 32'h5000; stride = 16'h10; cols = 11'd4; rows = 11'd2;
    fill_data = 32'h1; fill_strb = 4'hF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi_awvalid) begin seen = 1; break; end
    end
    check("t5_in_issue", 64'(seen), 64'(1));
    check("t5_err_cleared", 64'(err), 64'(0));
    #2; reset = 1'b1; #1;
    check("t5_awvalid_drop", 64'(axi_awvalid), 64'(0));
    check("t5_wvalid_drop", 64'(axi_wvalid), 64'(0));
    check("t5_busy_drop", 64'(busy), 64'(0));
    aw_delay = 0; w_delay = 0;
    repeat (2) @(posedge clk);
    #2; reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_done", 64'(done_cnt - d0), 64'(0));
    check("t5_idle", 64'(busy), 64'(0));

    // T6: start while busy is ignored
    a0 = aw_hs_cnt;
    run_job("t6", 32'h4000, 16'h100, 11'd2, 11'd2, 32'h5A5A0F0F, 4'h9, 1000, 1, lat);
    check("t6_latency", 64'(lat), 64'(18));
    check("t6_writes", 64'(aw_hs_cnt - a0), 64'(4));
    check("t6_err", 64'(err), 64'(0));

    // Address wrap past 2^32 with unaligned base
    run_job("wrap", 32'hFFFFFFFB, 16'h10, 11'd3, 11'd1, 32'hDEADBEEF, 4'hC, 1000, 0, lat);
    check("wrap_latency", 64'(lat), 64'(14));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
